// File: rtl/autotune_pkg.sv
// Shared definitions for the autotune pitch path: operand widths, the unity
// shift ratio and the divider state encoding.
package autotune_pkg;

  localparam int WIDTH     = 12;
  localparam int FRAC_BITS = 12;
  localparam int RATIO_W   = 16;

  localparam logic [RATIO_W-1:0] UNITY_RATIO = 16'h1000;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } div_state_t;

endpackage

// File: rtl/pitch_ratio_divider.sv
// Computes the pitch shift ratio closest_value/detected_val as unsigned Q4.12
// with a bit-serial restoring divider, one quotient bit per clock.
module pitch_ratio_divider #(
  parameter int WIDTH     = autotune_pkg::WIDTH,
  parameter int FRAC_BITS = autotune_pkg::FRAC_BITS,
  parameter int RATIO_W   = autotune_pkg::RATIO_W
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   detected_val,
  input  logic [WIDTH-1:0]   closest_value,
  input  logic               closest_value_found,
  output logic [RATIO_W-1:0] ratio_out,
  output logic               ratio_valid,
  output logic               ratio_sat,
  output logic               div_zero,
  output logic               busy
);

  localparam int DIV_BITS = WIDTH + FRAC_BITS;
  localparam int CNT_W    = $clog2(DIV_BITS);

  autotune_pkg::div_state_t state_q, state_d;

  logic                found_dly_q, found_dly_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [DIV_BITS-1:0] quot_q, quot_d;
  logic [DIV_BITS-1:0] num_q, num_d;
  logic [WIDTH-1:0]    den_q, den_d;
  logic [RATIO_W-1:0]  ratio_q, ratio_d;
  logic                valid_q, valid_d;
  logic                sat_q, sat_d;
  logic                dz_q, dz_d;

  logic                trigger;
  logic [WIDTH:0]      rem_shift;
  logic                q_bit;

  assign trigger = closest_value_found && !found_dly_q;

  always_comb begin
    state_d     = state_q;
    found_dly_d = closest_value_found;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    num_d       = num_q;
    den_d       = den_q;
    ratio_d     = ratio_q;
    valid_d     = 1'b0;
    sat_d       = sat_q;
    dz_d        = dz_q;
    rem_shift   = {rem_q, num_q[cnt_q]};
    q_bit       = (rem_shift >= {1'b0, den_q});

    case (state_q)
      autotune_pkg::IDLE: begin
        if (trigger) begin
          num_d   = {closest_value, {FRAC_BITS{1'b0}}};
          den_d   = detected_val;
          rem_d   = '0;
          quot_d  = '0;
          cnt_d   = CNT_W'(DIV_BITS - 1);
          state_d = autotune_pkg::DIVIDE;
        end
      end
      autotune_pkg::DIVIDE: begin
        // A zero divisor keeps every bit set; the result is overridden in DONE.
        rem_d  = q_bit ? (rem_shift[WIDTH-1:0] - den_q) : rem_shift[WIDTH-1:0];
        quot_d = {quot_q[DIV_BITS-2:0], q_bit};
        if (cnt_q == '0) begin
          state_d = autotune_pkg::DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      autotune_pkg::DONE: begin
        valid_d = 1'b1;
        state_d = autotune_pkg::IDLE;
        if (den_q == '0) begin
          ratio_d = '1;
          sat_d   = 1'b0;
          dz_d    = 1'b1;
        end else if (quot_q > {{(DIV_BITS-RATIO_W){1'b0}}, {RATIO_W{1'b1}}}) begin
          ratio_d = '1;
          sat_d   = 1'b1;
          dz_d    = 1'b0;
        end else begin
          ratio_d = quot_q[RATIO_W-1:0];
          sat_d   = 1'b0;
          dz_d    = 1'b0;
        end
      end
      default: state_d = autotune_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= autotune_pkg::IDLE;
      found_dly_q <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      num_q       <= '0;
      den_q       <= '0;
      ratio_q     <= RATIO_W'(autotune_pkg::UNITY_RATIO);
      valid_q     <= 1'b0;
      sat_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      found_dly_q <= found_dly_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      num_q       <= num_d;
      den_q       <= den_d;
      ratio_q     <= ratio_d;
      valid_q     <= valid_d;
      sat_q       <= sat_d;
      dz_q        <= dz_d;
    end
  end

  assign ratio_out   = ratio_q;
  assign ratio_valid = valid_q;
  assign ratio_sat   = sat_q;
  assign div_zero    = dz_q;
  assign busy        = (state_q != autotune_pkg::IDLE);

endmodule
